gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_ghr.sv | 61 ++++++
 rtl/gshare_predictor.sv | 133 +++++++++++++
 tb/tb_gshare_predictor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: index mode, resolved-branch update
// payload and the table-initialisation FSM states.
package bp_pkg;

    // Widest global history any predictor instance may carry on the update bus.
    localparam int unsigned BP_MAX_HIST = 16;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Resolved branch coming back from execute.
    typedef struct packed {
        logic                   en;
        logic [31:0]            pc;
        logic [BP_MAX_HIST-1:0] ghr;
        logic                   actual_taken;
        logic                   mispredict;
    } bp2_update_t;

endpackage

// File: rtl/bp_ghr.sv
// Speculative global history register.
//   clk, rst_n      : clock, synchronous active-low reset
//   run_i           : predictor is in RUN; history is forced to 0 otherwise
//   shift_en_i      : shift shift_bit_i in (speculative fetch)
//   restore_en_i    : mispredict recovery; beats a shift in the same cycle
//   restore_ghr_i   : history carried with the mispredicted branch
//   restore_bit_i   : its resolved direction
//   ghr_o           : current history
module bp_ghr #(
    parameter int unsigned HIST_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic                shift_en_i,
    input  logic                shift_bit_i,
    input  logic                restore_en_i,
    input  logic [HIST_LEN-1:0] restore_ghr_i,
    input  logic                restore_bit_i,
    output logic [HIST_LEN-1:0] ghr_o
);

    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [HIST_LEN-1:0] shifted, restored;

    // Single-bit history has no older bits to keep.
    generate
        if (HIST_LEN == 1) begin : g_h1
            logic unused_restore;
            assign unused_restore = restore_ghr_i[0];
            assign shifted        = shift_bit_i;
            assign restored       = restore_bit_i;
        end else begin : g_hn
            assign shifted  = {ghr_q[HIST_LEN-2:0], shift_bit_i};
            assign restored = {restore_ghr_i[HIST_LEN-2:0], restore_bit_i};
        end
    endgenerate

    // Restore wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (!run_i) begin
            ghr_d = '0;
        end else if (restore_en_i) begin
            ghr_d = restored;
        end else if (shift_en_i) begin
            ghr_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o = ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor with a self-initialising
// saturating-counter table.
//   clk, rst_n   : clock, synchronous active-low reset
//   query_pc     : fetch PC being predicted
//   query_valid  : fetch consumes the prediction; advances speculative history
//   pred_taken   : predicted direction (combinational from table + history)
//   pred_ghr     : history used for this prediction
//   ready        : table sweep finished
//   bp_update    : resolved branch (train counter, recover history)
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned TABLE_SIZE = 256,
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned HIST_LEN   = 8,
    parameter bp_mode_e    MODE       = BP_GSHARE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         query_pc,
    input  logic                query_valid,
    output logic                pred_taken,
    output logic [HIST_LEN-1:0] pred_ghr,
    output logic                ready,
    input  bp2_update_t         bp_update
);

    localparam int unsigned IDX = $clog2(TABLE_SIZE);
    localparam logic [CTR_WIDTH-1:0] INIT_VAL = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [IDX-1:0]       LAST_IDX = IDX'(TABLE_SIZE - 1);

    bp_state_e           state_q, state_d;
    logic [IDX-1:0]      sweep_q, sweep_d;
    logic [CTR_WIDTH-1:0] ctr_q [TABLE_SIZE];

    logic [HIST_LEN-1:0] ghr;
    logic [HIST_LEN-1:0] upd_ghr;
    logic [IDX-1:0]      q_idx, u_idx;
    logic [CTR_WIDTH-1:0] u_cur, u_next;
    logic                run;
    logic                we;
    logic [IDX-1:0]      waddr;
    logic [CTR_WIDTH-1:0] wdata;

    assign run     = (state_q == ST_RUN);
    assign upd_ghr = bp_update.ghr[HIST_LEN-1:0];

    // Bimodal ignores history; gshare folds zero-extended history into the PC bits.
    assign q_idx = (MODE == BP_GSHARE) ? (query_pc[IDX+1:2] ^ IDX'(ghr))
                                       : query_pc[IDX+1:2];
    assign u_idx = (MODE == BP_GSHARE) ? (bp_update.pc[IDX+1:2] ^ IDX'(upd_ghr))
                                       : bp_update.pc[IDX+1:2];

    // Saturating step of the counter being trained.
    assign u_cur = ctr_q[u_idx];
    always_comb begin
        u_next = u_cur;
        if (bp_update.actual_taken) begin
            if (u_cur != CTR_MAX) u_next = u_cur + CTR_WIDTH'(1);
        end else begin
            if (u_cur != '0) u_next = u_cur - CTR_WIDTH'(1);
        end
    end

    // Init sweep / run FSM; also muxes the single table write port.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        we      = 1'b0;
        waddr   = u_idx;
        wdata   = u_next;
        case (state_q)
            ST_INIT: begin
                we      = 1'b1;
                waddr   = sweep_q;
                wdata   = INIT_VAL;
                sweep_d = sweep_q + IDX'(1);
                if (sweep_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                we = bp_update.en;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Counter table: no reset, contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (we) ctr_q[waddr] <= wdata;
    end

    bp_ghr #(
        .HIST_LEN (HIST_LEN)
    ) u_ghr (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .shift_en_i    (query_valid),
        .shift_bit_i   (pred_taken),
        .restore_en_i  (bp_update.en & bp_update.mispredict),
        .restore_ghr_i (upd_ghr),
        .restore_bit_i (bp_update.actual_taken),
        .ghr_o         (ghr)
    );

    // Query reads the pre-update table value; no write bypass.
    assign pred_taken = run & ctr_q[q_idx][CTR_WIDTH-1];
    assign pred_ghr   = ghr;
    assign ready      = run;

    // PC bits outside the index field and unused history bits.
    logic unused_pc;
    assign unused_pc = ^{query_pc[31:IDX+2], query_pc[1:0],
                         bp_update.pc[31:IDX+2], bp_update.pc[1:0]};
    generate
        if (HIST_LEN < BP_MAX_HIST) begin : g_hist_unused
            logic unused_hist;
            assign unused_hist = ^bp_update.ghr[BP_MAX_HIST-1:HIST_LEN];
        end
    endgenerate

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: three predictor instances (bimodal, gshare, 3-bit bimodal),
// 16 entries, 4-bit history.
module tb_gshare_predictor;
    import bp_pkg::*;

    localparam int NDUT = 3;
    localparam int BIM  = 0;
    localparam int GSH  = 1;
    localparam int C3   = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] q_pc  [NDUT];
    logic        q_v   [NDUT];
    bp2_update_t upd   [NDUT];
    logic        pt    [NDUT];
    logic [3:0]  pg    [NDUT];
    logic        rdy   [NDUT];

    int total;
    int bad;

    gshare_predictor #(.TABLE_SIZE(16), .CTR_WIDTH(2), .HIST_LEN(4), .MODE(BP_BIMODAL)) u_bim (
        .clk(clk), .rst_n(rst_n), .query_pc(q_pc[BIM]), .query_valid(q_v[BIM]),
        .pred_taken(pt[BIM]), .pred_ghr(pg[BIM]), .ready(rdy[BIM]), .bp_update(upd[BIM]));

    gshare_predictor #(.TABLE_SIZE(16), .CTR_WIDTH(2), .HIST_LEN(4), .MODE(BP_GSHARE)) u_gsh (
        .clk(clk), .rst_n(rst_n), .query_pc(q_pc[GSH]), .query_valid(q_v[GSH]),
        .pred_taken(pt[GSH]), .pred_ghr(pg[GSH]), .ready(rdy[GSH]), .bp_update(upd[GSH]));

    gshare_predictor #(.TABLE_SIZE(16), .CTR_WIDTH(3), .HIST_LEN(4), .MODE(BP_BIMODAL)) u_c3 (
        .clk(clk), .rst_n(rst_n), .query_pc(q_pc[C3]), .query_valid(q_v[C3]),
        .pred_taken(pt[C3]), .pred_ghr(pg[C3]), .ready(rdy[C3]), .bp_update(upd[C3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < NDUT; d++) begin
            q_pc[d] = 32'h0;
            q_v[d]  = 1'b0;
            upd[d]  = '0;
        end
    endtask

    task automatic do_update(input int d, input logic [31:0] pc, input logic [3:0] g,
                             input logic taken, input logic mp);
        upd[d].en           = 1'b1;
        upd[d].pc           = pc;
        upd[d].ghr          = 16'(g);
        upd[d].actual_taken = taken;
        upd[d].mispredict   = mp;
        step();
        upd[d] = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        // Activity during the sweep must be ignored.
        q_v[GSH]              = 1'b1;
        upd[GSH].en           = 1'b1;
        upd[GSH].mispredict   = 1'b1;
        upd[GSH].actual_taken = 1'b1;
        upd[GSH].ghr          = 16'h0005;
        for (int c = 0; c < 16; c++) begin
            q_pc[GSH] = 32'(c) << 2;
            #1;
            for (int d = 0; d < NDUT; d++) begin
                total++;
                if (rdy[d] !== 1'b0) begin
                    $display("FAIL init_ready dut=%0d cyc=%0d got=%b exp=0", d, c, rdy[d]);
                    bad++;
                end
            end
            total++;
            if (pt[GSH] !== 1'b0 || pg[GSH] !== 4'h0) begin
                $display("FAIL init_pred cyc=%0d got pt=%b ghr=%h exp pt=0 ghr=0", c, pt[GSH], pg[GSH]);
                bad++;
            end
            step();
        end
        clear_inputs();
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (rdy[d] !== 1'b1) begin
                $display("FAIL ready_rise dut=%0d got=%b exp=1", d, rdy[d]);
                bad++;
            end
        end
        for (int p = 0; p < 16; p++) begin
            for (int d = 0; d < NDUT; d++) q_pc[d] = 32'(p) << 2;
            #1;
            for (int d = 0; d < NDUT; d++) begin
                total++;
                if (pt[d] !== 1'b0 || pg[d] !== 4'h0) begin
                    $display("FAIL post_init dut=%0d idx=%0d got pt=%b ghr=%h exp pt=0 ghr=0",
                             d, p, pt[d], pg[d]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_bimodal();
        q_pc[BIM] = 32'h40;
        do_update(BIM, 32'h40, 4'h0, 1'b1, 1'b0);
        do_update(BIM, 32'h40, 4'h0, 1'b1, 1'b0);
        total++;
        if (pt[BIM] !== 1'b1) begin
            $display("FAIL bim_2taken got=%b exp=1", pt[BIM]); bad++;
        end
        for (int i = 0; i < 3; i++) do_update(BIM, 32'h40, 4'h0, 1'b1, 1'b0);
        total++;
        if (pt[BIM] !== 1'b1) begin
            $display("FAIL bim_sat got=%b exp=1", pt[BIM]); bad++;
        end
        do_update(BIM, 32'h40, 4'h0, 1'b0, 1'b0);
        total++;
        if (pt[BIM] !== 1'b1) begin
            $display("FAIL bim_1nt got=%b exp=1", pt[BIM]); bad++;
        end
        do_update(BIM, 32'h40, 4'h0, 1'b0, 1'b0);
        total++;
        if (pt[BIM] !== 1'b0) begin
            $display("FAIL bim_2nt got=%b exp=0", pt[BIM]); bad++;
        end
        q_pc[BIM] = 32'h44;
        #1;
        total++;
        if (pt[BIM] !== 1'b0) begin
            $display("FAIL bim_other got=%b exp=0", pt[BIM]); bad++;
        end
    endtask

    task automatic test_gshare_alias();
        do_update(GSH, 32'h40, 4'b0011, 1'b1, 1'b0);
        do_update(GSH, 32'h40, 4'b0011, 1'b1, 1'b0);
        q_pc[GSH] = 32'h4C;
        #1;
        total++;
        if (pt[GSH] !== 1'b1 || pg[GSH] !== 4'h0) begin
            $display("FAIL gsh_alias_4c got pt=%b ghr=%h exp pt=1 ghr=0", pt[GSH], pg[GSH]); bad++;
        end
        q_pc[GSH] = 32'h40;
        #1;
        total++;
        if (pt[GSH] !== 1'b0) begin
            $display("FAIL gsh_alias_40 got=%b exp=0", pt[GSH]); bad++;
        end
    endtask

    task automatic test_recovery();
        // Query predicts taken (entry 3) but the same-cycle mispredict wins.
        q_pc[GSH] = 32'h4C;
        q_v[GSH]  = 1'b1;
        do_update(GSH, 32'h40, 4'b0101, 1'b1, 1'b1);
        q_v[GSH] = 1'b0;
        total++;
        if (pg[GSH] !== 4'b1011) begin
            $display("FAIL recover_ghr got=%b exp=1011", pg[GSH]); bad++;
        end
        // GHR 1011: pc idx 8 -> entry 3 (taken), shift in 1.
        q_pc[GSH] = 32'(8) << 2;
        q_v[GSH]  = 1'b1;
        #1;
        total++;
        if (pt[GSH] !== 1'b1) begin
            $display("FAIL shift1_pred got=%b exp=1", pt[GSH]); bad++;
        end
        step();
        total++;
        if (pg[GSH] !== 4'b0111) begin
            $display("FAIL shift1_ghr got=%b exp=0111", pg[GSH]); bad++;
        end
        // GHR 0111: pc idx 0 -> entry 7 (weak not-taken), shift in 0.
        q_pc[GSH] = 32'h0;
        #1;
        total++;
        if (pt[GSH] !== 1'b0) begin
            $display("FAIL shift0_pred got=%b exp=0", pt[GSH]); bad++;
        end
        step();
        q_v[GSH] = 1'b0;
        total++;
        if (pg[GSH] !== 4'b1110) begin
            $display("FAIL shift0_ghr got=%b exp=1110", pg[GSH]); bad++;
        end
        // Mispredict-cycle update trained entry 5: pc idx 11 ^ 1110 = 5.
        q_pc[GSH] = 32'(11) << 2;
        step();
        total++;
        if (pt[GSH] !== 1'b1 || pg[GSH] !== 4'b1110) begin
            $display("FAIL recover_train got pt=%b ghr=%b exp pt=1 ghr=1110", pt[GSH], pg[GSH]); bad++;
        end
    endtask

    task automatic test_back_to_back();
        // Query and update hit entry 9 in the same cycle: query sees old value.
        q_pc[GSH]             = 32'(7) << 2;
        upd[GSH].en           = 1'b1;
        upd[GSH].pc           = 32'(9) << 2;
        upd[GSH].ghr          = 16'h0;
        upd[GSH].actual_taken = 1'b1;
        #1;
        total++;
        if (pt[GSH] !== 1'b0) begin
            $display("FAIL same_idx_pre got=%b exp=0", pt[GSH]); bad++;
        end
        step();
        upd[GSH] = '0;
        #1;
        total++;
        if (pt[GSH] !== 1'b1) begin
            $display("FAIL same_idx_post got=%b exp=1", pt[GSH]); bad++;
        end
    endtask

    task automatic test_ctr3();
        q_pc[C3] = 32'h40;
        do_update(C3, 32'h40, 4'h0, 1'b1, 1'b0);
        total++;
        if (pt[C3] !== 1'b1) begin
            $display("FAIL c3_1taken got=%b exp=1", pt[C3]); bad++;
        end
        for (int i = 0; i < 4; i++) do_update(C3, 32'h40, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_update(C3, 32'h40, 4'h0, 1'b0, 1'b0);
        total++;
        if (pt[C3] !== 1'b1) begin
            $display("FAIL c3_3nt got=%b exp=1", pt[C3]); bad++;
        end
        do_update(C3, 32'h40, 4'h0, 1'b0, 1'b0);
        total++;
        if (pt[C3] !== 1'b0) begin
            $display("FAIL c3_4nt got=%b exp=0", pt[C3]); bad++;
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) step();
        total++;
        if (rdy[GSH] !== 1'b0) begin
            $display("FAIL mid_sweep_ready got=%b exp=0", rdy[GSH]); bad++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            total++;
            if (rdy[GSH] !== 1'b0) begin
                $display("FAIL restart_ready cyc=%0d got=%b exp=0", c, rdy[GSH]); bad++;
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (rdy[d] !== 1'b1) begin
                $display("FAIL restart_rise dut=%0d got=%b exp=1", d, rdy[d]); bad++;
            end
        end
        for (int p = 0; p < 16; p++) begin
            for (int d = 0; d < NDUT; d++) q_pc[d] = 32'(p) << 2;
            #1;
            for (int d = 0; d < NDUT; d++) begin
                total++;
                if (pt[d] !== 1'b0 || pg[d] !== 4'h0) begin
                    $display("FAIL restart_entry dut=%0d idx=%0d got pt=%b ghr=%h exp pt=0 ghr=0",
                             d, p, pt[d], pg[d]);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_bimodal();
        test_gshare_alias();
        test_recovery();
        test_back_to_back();
        test_ctr3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
